// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - requester/transmitter handshake bundle for tx_arbiter
interface tx_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 3
) ();
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic                en;
  logic [N-1:0]        req;
  logic [N*DATA_W-1:0] req_data;
  logic                busy;
  logic                tx;
  logic [DATA_W-1:0]   data;
  logic [N-1:0]        grant;
  logic                done;
  logic                err_timeout;
  logic [ID_W-1:0]     active_id;

  // Client/transmitter side
  modport master (
    output en, req, req_data, busy,
    input  tx, data, grant, done, err_timeout, active_id
  );

  // Arbiter side
  modport slave (
    input  en, req, req_data, busy,
    output tx, data, grant, done, err_timeout, active_id
  );
endinterface

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin launcher sharing one transmitter among N requesters
module tx_arbiter #(
  parameter int N       = 4,
  parameter int DATA_W  = 3,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         reset,
  tx_arbiter_if.slave  bus
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;
  // Last counter value tolerated in WAIT_BUSY before giving up
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_tx,        w_tx_nxt;
  logic [N-1:0]      r_grant,     w_grant_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_err,       w_err_nxt;
  logic [DATA_W-1:0] r_data,      w_data_nxt;
  logic [ID_W-1:0]   r_active_id, w_id_nxt;
  logic [7:0]        r_cnt,       w_cnt_nxt;
  logic [ID_W-1:0]   r_last,      w_last_nxt;

  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [DATA_W-1:0] w_payload [N];

  // Slice the flat payload bus into one entry per requester
  for (genvar gi = 0; gi < N; gi++) begin : g_payload
    assign w_payload[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: first pending request after the last winner, wrapping at N
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int i = 1; i <= N; i++) begin
      v_idx = (int'(r_last) + i) % N;
      if (!w_found && bus.req[v_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b0;
    w_grant_nxt = '0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_data_nxt  = r_data;
    w_id_nxt    = r_active_id;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        // A busy transmitter blocks new launches even when idle here
        if (bus.en && !bus.busy && w_found) begin
          w_state_nxt = S_LAUNCH;
          w_data_nxt  = w_payload[w_win];
          w_id_nxt    = w_win;
          w_tx_nxt    = 1'b1;
          w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_win;
        end
      end
      S_LAUNCH: begin
        // Pointer advances on every grant, even ones that later time out
        w_last_nxt = r_active_id;
        if (bus.busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_state_nxt = S_WAIT_BUSY;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.busy) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset overrides any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tx        <= 1'b0;
      r_grant     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
      r_active_id <= '0;
      r_cnt       <= '0;
      r_last      <= ID_W'(N - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_tx        <= w_tx_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_data      <= w_data_nxt;
      r_active_id <= w_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign bus.tx          = r_tx;
  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.err_timeout = r_err;
  assign bus.data        = r_data;
  assign bus.active_id   = r_active_id;
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin controller that shares the single 3-bit `fsm` transmitter among N requesters. It picks one pending request and launches it into the transmitter as a one-cycle `tx` strobe with stable `data`. It then tracks the transmitter's `busy` handshake to completion and reports done or timeout to the winner. It sits between the client blocks and the `fsm` instance and drives that instance's `tx`/`data` inputs directly.

## Interface
- `N`, default 4: number of requesters (2..8).
- `DATA_W`, default 3: payload width; must match the transmitter's `data`.
- `TIMEOUT`, default 8: maximum cycles in WAIT_BUSY before the transfer is abandoned (1..255).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  when low, no new grant is issued; an in-flight transfer still completes.
- `req`  in  N  per-requester request level; held until that requester's `grant`.
- `req_data`  in  N*DATA_W  payloads; requester i uses bits [i*DATA_W +: DATA_W]; stable while `req[i]` is high.
- `busy`  in  1  transmitter busy flag.
- `tx`  out  1  one-cycle launch strobe to the transmitter.
- `data`  out  DATA_W  payload to the transmitter.
- `grant`  out  N  one-hot; pulses for one cycle, coincident with `tx`.
- `done`  out  1  one-cycle pulse when the granted transfer finishes.
- `err_timeout`  out  1  one-cycle pulse when `busy` never rose.
- `active_id`  out  clog2(N)  index of the current or last winner.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE. All outputs are registered.
- IDLE:
  - Advances only when `en`=1, `busy`=0 and `|req`=1.
  - Winner = first set bit of `req`, searching from `last+1` upward and wrapping at N.
  - Latches the winner's payload into `data` and the winner's index into `active_id`.
  - Next state is LAUNCH.
- LAUNCH (exactly 1 cycle):
  - `tx`=1 and `grant[active_id]`=1.
  - Sets `last`=`active_id`.
  - If `busy`=1 is sampled at the end of this cycle, go to WAIT_DONE; otherwise go to WAIT_BUSY with the counter cleared.
- WAIT_BUSY:
  - Counter increments each cycle.
  - `busy`=1 goes to WAIT_DONE.
  - If the counter reaches TIMEOUT-1 with `busy`=0, pulse `err_timeout` and return to IDLE.
- WAIT_DONE:
  - `busy`=0 pulses `done` and returns to IDLE.
  - There is no timeout in this state.
- `data` holds its value from LAUNCH until the next winner is latched; it never changes while the transmitter is busy.
- A requester that drops `req` before being granted is simply skipped; there is no error.
- `en` falling during LAUNCH, WAIT_BUSY or WAIT_DONE has no effect on the transfer in progress.
- Round-robin pointer `last` resets to N-1, so requester 0 has first priority after reset.
- The pointer advances on every grant, including grants that later time out.

## Timing
- Reset (sampled on a `clk` edge): state=IDLE, `tx`=0, `grant`=0, `done`=0, `err_timeout`=0, `data`=0, `active_id`=0, counter=0, `last`=N-1. Reset wins over every other condition in every state, including mid-transfer; `tx` never glitches high during reset.
- Request to launch:
  - `req` seen in IDLE at edge k gives `tx`/`grant` high in cycle k→k+1.
  - Minimum latency is one cycle.
- Completion:
  - `busy` seen low in WAIT_DONE at edge m gives `done` high in cycle m→m+1 and state IDLE.
  - The next `tx` can occur no earlier than edge m+1, i.e. one idle cycle between back-to-back transfers.
- Timeout:
  - LAUNCH at cycle 0 with `busy` held 0 gives `err_timeout` high in cycle TIMEOUT+1.
  - `tx` is never reissued automatically; the requester must re-request.
- `busy`=1 while in IDLE blocks all grants until it falls.
- `done`, `err_timeout` and `tx` are mutually exclusive in any cycle.

## Test plan
- Reset: assert `reset` for 2 cycles with `req`=4'b1111 → all outputs at their reset values, no `tx`. After release, first grant is requester 0.
- Single request: `req`=4'b0100, payload 3'b101. Transmitter model raises `busy` 1 cycle after `tx` and holds it 4 cycles → `tx`/`grant`=4'b0100 one cycle after the request, `data`=3'b101 held throughout, `done` pulses once, `active_id`=2.
- Contention: `req`=4'b1111 held, payloads 0..3 → grant order 0,1,2,3,0. Exactly one `tx` per transfer; no `tx` while `busy`=1.
- Timeout: TIMEOUT=8, `busy` tied 0, `req`=4'b0010 → `err_timeout` pulses 9 cycles after `tx`, state returns to IDLE, no `done`. The next grant with `req`=4'b1010 goes to requester 3.
- Reset mid-transfer: assert `reset` during WAIT_DONE with `busy`=1 → next cycle all outputs at reset values. After release with `busy` still 1, no grant until `busy` falls.
- Gating: `en`=0 with `req`=4'b0001 → no `tx` for 10 cycles. Set `en`=1 → `tx` on the next cycle. Dropping `en` mid-transfer still produces `done`.
